// File: rtl/kudu_stats_ctrl.sv
// -----------------------------------------------------------------------------
// kudu_stats_ctrl
//   Command decoder for the kudu_stats perf-counter block. It snoops core
//   data-side stores to a mailbox word address and turns the commands it finds
//   into single-cycle start/stop toggle pulses and a held print request.
//   It tracks the downstream count enable and runs fixed-length measurement
//   windows that auto-stop and auto-request a stats print when they expire.
//
//   Commands (wr_data_i[3:0]): 1=START 2=STOP 3=PRINT 4=WINDOW, others illegal.
//   WINDOW length is taken from wr_data_i[8 +: WIN_W].
//
// Ports
//   clk_i          in   1   clock
//   rst_i          in   1   synchronous active-high reset
//   wr_valid_i     in   1   core store accepted this cycle
//   wr_addr_i      in   32  store address
//   wr_data_i      in   32  store data: [3:0] cmd, [31:8] window length
//   start_stop_o   out  1   1-cycle pulse; downstream toggles its count enable
//   print_req_o    out  1   print request level (downstream acts on rise)
//   cnt_active_o   out  1   mirror of downstream count enable
//   window_busy_o  out  1   measurement window in progress
//   cmd_err_o      out  1   1-cycle pulse: illegal/rejected command
//   fsm_state_o    out  2   current FSM state (0=IDLE 1=RUN 2=WIN), debug
//
// Handshake: a command is taken in any cycle where wr_valid_i is high and
// wr_addr_i equals MBOX_ADDR; there is no back-pressure. Every response is
// registered and becomes visible in the following cycle.
// -----------------------------------------------------------------------------
module kudu_stats_ctrl #(
    parameter logic [31:0] MBOX_ADDR  = 32'h8000_0F00,
    parameter int          PRINT_HOLD = 4,
    parameter int          WIN_W      = 24
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        wr_valid_i,
    input  logic [31:0] wr_addr_i,
    input  logic [31:0] wr_data_i,
    output logic        start_stop_o,
    output logic        print_req_o,
    output logic        cnt_active_o,
    output logic        window_busy_o,
    output logic        cmd_err_o,
    output logic [1:0]  fsm_state_o
);

    localparam int HW = $clog2(PRINT_HOLD + 1);

    localparam logic [3:0] CMD_START  = 4'd1;
    localparam logic [3:0] CMD_STOP   = 4'd2;
    localparam logic [3:0] CMD_PRINT  = 4'd3;
    localparam logic [3:0] CMD_WINDOW = 4'd4;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_WIN  = 2'd2
    } state_t;

    state_t           state, state_n;
    logic [WIN_W-1:0] win_cnt, win_n;
    logic [HW-1:0]    hold_cnt;
    logic             print_gap;
    logic             auto_pend;
    logic             pulse_n, err_n, expiry, print_cmd, fire;

    logic             accept;
    logic [3:0]       cmd;
    logic [WIN_W-1:0] win_len;
    logic             is_start, is_stop, is_window;
    logic             unused_data;

    assign accept    = wr_valid_i && (wr_addr_i == MBOX_ADDR);
    assign cmd       = wr_data_i[3:0];
    assign win_len   = wr_data_i[8 +: WIN_W];
    assign is_start  = accept && (cmd == CMD_START);
    assign is_stop   = accept && (cmd == CMD_STOP);
    assign is_window = accept && (cmd == CMD_WINDOW);
    assign unused_data = ^wr_data_i[7:4];

    // Next-state / pulse logic. START/STOP arriving while a toggle pulse is
    // already on the wire are dropped so two pulses never abut; a WINDOW in
    // that cycle is rejected. WINDOW(1) is the one exception: honouring a
    // one-cycle count needs the stop pulse right after the start pulse.
    always_comb begin
        state_n   = state;
        win_n     = win_cnt;
        pulse_n   = 1'b0;
        err_n     = 1'b0;
        expiry    = 1'b0;
        print_cmd = accept && (cmd == CMD_PRINT);
        if (accept && !(cmd inside {CMD_START, CMD_STOP, CMD_PRINT, CMD_WINDOW}))
            err_n = 1'b1;
        case (state)
            S_IDLE: begin
                if (is_start && !start_stop_o) begin
                    state_n = S_RUN;
                    pulse_n = 1'b1;
                end else if (is_window) begin
                    if (win_len == '0 || start_stop_o) begin
                        err_n = 1'b1;
                    end else begin
                        state_n = S_WIN;
                        pulse_n = 1'b1;
                        win_n   = win_len;
                    end
                end
            end
            S_RUN: begin
                if (is_stop && !start_stop_o) begin
                    state_n = S_IDLE;
                    pulse_n = 1'b1;
                end else if (is_window) begin
                    err_n = 1'b1;
                end
            end
            S_WIN: begin
                if (is_window)
                    err_n = 1'b1;
                // Expiry wins over a coincident STOP: one pulse, auto-print.
                if (win_cnt == WIN_W'(1)) begin
                    expiry  = 1'b1;
                    state_n = S_IDLE;
                    pulse_n = 1'b1;
                    win_n   = '0;
                end else begin
                    win_n = win_cnt - WIN_W'(1);
                    if (is_stop && !start_stop_o) begin
                        state_n = S_IDLE;
                        pulse_n = 1'b1;
                        win_n   = '0;
                    end
                end
            end
            default: begin
                state_n = S_IDLE;
                win_n   = '0;
            end
        endcase
    end

    // A print may only rise when the request is low and the mandatory low
    // cycle after the previous hold has passed.
    assign fire = !print_req_o && !print_gap && (auto_pend || print_cmd);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state        <= S_IDLE;
            win_cnt      <= '0;
            start_stop_o <= 1'b0;
            cmd_err_o    <= 1'b0;
            print_req_o  <= 1'b0;
            hold_cnt     <= '0;
            print_gap    <= 1'b0;
            auto_pend    <= 1'b0;
        end else begin
            state        <= state_n;
            win_cnt      <= win_n;
            start_stop_o <= pulse_n;
            cmd_err_o    <= err_n;
            print_gap    <= print_req_o && (hold_cnt == HW'(1));
            if (fire) begin
                print_req_o <= 1'b1;
                hold_cnt    <= HW'(PRINT_HOLD);
            end else if (print_req_o) begin
                if (hold_cnt == HW'(1)) begin
                    print_req_o <= 1'b0;
                    hold_cnt    <= '0;
                end else begin
                    hold_cnt <= hold_cnt - HW'(1);
                end
            end
            // A PRINT command firing in the expiry cycle absorbs the auto-print;
            // a fire that consumed an older pending one leaves the new one queued.
            if (fire)
                auto_pend <= expiry && auto_pend;
            else
                auto_pend <= auto_pend || expiry;
        end
    end

    assign cnt_active_o  = (state != S_IDLE);
    assign window_busy_o = (state == S_WIN);
    assign fsm_state_o   = state;

endmodule
